// File: rtl/cycle_timer_pkg.sv
// cycle_timer_pkg: shared state encoding and mode constants for the cycle timer.
// Revision: 1.0
`default_nettype none

package cycle_timer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cycle_timer_tick_prescaler.sv
// tick_prescaler: divides the clock into a tick strobe every PRESCALE enabled cycles.
// Revision: 1.0
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clock, reset, clear};
      assign tick = enable;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
      logic [CW-1:0] cnt;

      // clear wins over counting so a restart always begins a full interval
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end

      assign tick = enable && (cnt == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cycle_timer.sv
// cycle_timer: programmable down-counter producing one-shot or periodic terminal-count pulses.
// Revision: 1.0
`default_nettype none

module cycle_timer
  import cycle_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             tick;
  logic [WIDTH-1:0] start_value;
  logic             start_ok;
  logic             run;

  // a same-cycle load bypasses the reload register so start sees the new period
  assign start_value = load ? load_value : reload;
  assign start_ok    = start && (start_value != '0);
  assign run         = (state == ST_RUN);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (start_ok && !stop),
    .enable(run),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      mode  <= MODE_ONESHOT;
    end else begin
      tc <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (start_ok) begin
        state <= ST_RUN;
        busy  <= 1'b1;
        count <= start_value;
        mode  <= periodic;
      end else if (run && tick) begin
        // treating 0 as terminal too keeps the counter from ever wrapping
        if (count <= WIDTH'(1)) begin
          tc <= 1'b1;
          if (mode == MODE_PERIODIC) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cycle_timer.sv
// tb_cycle_timer: directed self-checking bench for cycle_timer (PRESCALE 1 and 4 instances).
// Revision: 1.0
`default_nettype none

module tb_cycle_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       load = 1'b0, periodic = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] count;
  logic       tc, busy;

  logic       load4 = 1'b0, periodic4 = 1'b0, start4 = 1'b0, stop4 = 1'b0;
  logic [7:0] load_value4 = 8'd0;
  logic [7:0] count4;
  logic       tc4, busy4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  cycle_timer #(.WIDTH(8), .PRESCALE(1)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .periodic(periodic), .start(start), .stop(stop),
    .count(count), .tc(tc), .busy(busy)
  );

  cycle_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clock(clock), .reset(reset), .load(load4), .load_value(load_value4),
    .periodic(periodic4), .start(start4), .stop(stop4),
    .count(count4), .tc(tc4), .busy(busy4)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // observed values are packed as {count, busy, tc}
  task automatic test_reset();
    #2;
    compared++;
    if ({count, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_init: got %h want %h", {count, busy, tc}, {8'd0, 1'b0, 1'b0});
    end
    cyc();
    reset = 1'b0;
    cyc();
    load = 1'b1; load_value = 8'd10; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    compared++;
    if ({count, busy, tc} !== {8'd5, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_prerun: got %h want %h", {count, busy, tc}, {8'd5, 1'b1, 1'b0});
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({count, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_async: got %h want %h", {count, busy, tc}, {8'd0, 1'b0, 1'b0});
    end
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      compared++;
      if ({count, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_after[%0d]: got %h want %h", i, {count, busy, tc}, {8'd0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_oneshot();
    logic [9:0] want;
    load = 1'b1; load_value = 8'd4; periodic = 1'b0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4)       want = {8'(4 - i), 1'b1, 1'b0};
      else if (i == 4) want = {8'd0, 1'b0, 1'b1};
      else             want = {8'd0, 1'b0, 1'b0};
      compared++;
      if ({count, busy, tc} !== want) begin
        mismatched++;
        $display("FAIL oneshot[%0d]: got %h want %h", i, {count, busy, tc}, want);
      end
      cyc();
    end
  endtask

  task automatic test_periodic();
    logic [9:0] want;
    load = 1'b1; load_value = 8'd3; periodic = 1'b1; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0; periodic = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c == 0)          want = {8'd3, 1'b1, 1'b0};
      else if (c % 3 == 0) want = {8'd3, 1'b1, 1'b1};
      else                 want = {8'(3 - (c % 3)), 1'b1, 1'b0};
      compared++;
      if ({count, busy, tc} !== want) begin
        mismatched++;
        $display("FAIL periodic[%0d]: got %h want %h", c, {count, busy, tc}, want);
      end
      if (c < 16) cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({count, busy, tc} !== {8'd2, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL periodic_stop[%0d]: got %h want %h", i, {count, busy, tc}, {8'd2, 1'b0, 1'b0});
      end
      cyc();
    end
  endtask

  task automatic test_prescale();
    logic [9:0] want;
    load4 = 1'b1; load_value4 = 8'd2; periodic4 = 1'b0; start4 = 1'b1;
    cyc();
    load4 = 1'b0; start4 = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 4)       want = {8'd2, 1'b1, 1'b0};
      else if (i < 8)  want = {8'd1, 1'b1, 1'b0};
      else if (i == 8) want = {8'd0, 1'b0, 1'b1};
      else             want = {8'd0, 1'b0, 1'b0};
      compared++;
      if ({count4, busy4, tc4} !== want) begin
        mismatched++;
        $display("FAIL prescale[%0d]: got %h want %h", i, {count4, busy4, tc4}, want);
      end
      cyc();
    end
  endtask

  task automatic test_zero_load();
    load = 1'b1; load_value = 8'd0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({count, busy, tc} !== {8'd2, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL zero_start[%0d]: got %h want %h", i, {count, busy, tc}, {8'd2, 1'b0, 1'b0});
      end
      cyc();
    end
    load = 1'b1; load_value = 8'd6; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    compared++;
    if ({count, busy, tc} !== {8'd6, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL load_bypass: got %h want %h", {count, busy, tc}, {8'd6, 1'b1, 1'b0});
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    compared++;
    if ({count, busy, tc} !== {8'd6, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL bypass_stop: got %h want %h", {count, busy, tc}, {8'd6, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reload_midrun();
    logic [9:0] want;
    logic [9:0] exp_tab [0:8];
    exp_tab[0] = {8'd5, 1'b1, 1'b0};
    exp_tab[1] = {8'd4, 1'b1, 1'b0};
    exp_tab[2] = {8'd3, 1'b1, 1'b0};
    exp_tab[3] = {8'd2, 1'b1, 1'b0};
    exp_tab[4] = {8'd1, 1'b1, 1'b0};
    exp_tab[5] = {8'd2, 1'b1, 1'b1};
    exp_tab[6] = {8'd1, 1'b1, 1'b0};
    exp_tab[7] = {8'd2, 1'b1, 1'b1};
    exp_tab[8] = {8'd1, 1'b1, 1'b0};
    load = 1'b1; load_value = 8'd5; periodic = 1'b1; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0; periodic = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      want = exp_tab[c];
      compared++;
      if ({count, busy, tc} !== want) begin
        mismatched++;
        $display("FAIL reload_mid[%0d]: got %h want %h", c, {count, busy, tc}, want);
      end
      if (c == 2) begin
        load = 1'b1; load_value = 8'd2;
      end else begin
        load = 1'b0;
      end
      if (c < 8) cyc();
    end
    load = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({count, busy, tc} !== {8'd1, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL stop_at_tc[%0d]: got %h want %h", i, {count, busy, tc}, {8'd1, 1'b0, 1'b0});
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_prescale();
    test_zero_load();
    test_reload_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
